// File: rtl/zx_int_pkg.sv
// rtl/zx_int_pkg.sv - shared state encoding, source codes and priority encoder for zx_int_ctrl
package zx_int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    localparam logic [1:0] SRC_NONE  = 2'b00;
    localparam logic [1:0] SRC_W5300 = 2'b01;
    localparam logic [1:0] SRC_SL811 = 2'b10;
    localparam logic [1:0] SRC_INT   = 2'b11;

    // Fixed priority: W5300 over SL811 over internal.
    function automatic logic [1:0] prio_src(input logic rw, input logic rs, input logic ri);
        if (rw) begin
            return SRC_W5300;
        end else if (rs) begin
            return SRC_SL811;
        end else if (ri) begin
            return SRC_INT;
        end
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/zx_sync2.sv
// rtl/zx_sync2.sv - two-flop synchroniser with async reset to a selectable inactive level
module zx_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/zx_int_ctrl.sv
// rtl/zx_int_ctrl.sv - ZX bus /INT pulse scheduler; ZX_INT_STATS_EN adds the delivered-interrupt counter
module zx_int_ctrl
    import zx_int_pkg::*;
#(
    parameter int INT_LEN     = 32,
    parameter int HOLDOFF_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       w5300_int_n,
    input  logic       sl811_intrq,
    input  logic       internal_int,
    input  logic       ena_w5300_int,
    input  logic       ena_sl811_int,
    input  logic       ena_zxbus_int,
    input  logic       zx_m1_n,
    input  logic       zx_iorq_n,
    output logic       int_n,
    output logic [1:0] int_src,
    output logic       int_ack,
    output logic       int_timeout,
    output logic [7:0] int_count,
    input  logic       stats_clr
);

    localparam int CNT_MAX = (INT_LEN > HOLDOFF_LEN) ? INT_LEN : HOLDOFF_LEN;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic w5300_n_s, sl811_s, internal_s, m1_n_s, iorq_n_s;

    zx_sync2 #(.RST_VAL(1'b1)) u_sync_w5300 (.clk(clk), .rst(rst), .d(w5300_int_n),  .q(w5300_n_s));
    zx_sync2 #(.RST_VAL(1'b0)) u_sync_sl811 (.clk(clk), .rst(rst), .d(sl811_intrq),  .q(sl811_s));
    zx_sync2 #(.RST_VAL(1'b0)) u_sync_int   (.clk(clk), .rst(rst), .d(internal_int), .q(internal_s));
    zx_sync2 #(.RST_VAL(1'b1)) u_sync_m1    (.clk(clk), .rst(rst), .d(zx_m1_n),      .q(m1_n_s));
    zx_sync2 #(.RST_VAL(1'b1)) u_sync_iorq  (.clk(clk), .rst(rst), .d(zx_iorq_n),    .q(iorq_n_s));

    logic rw, rs, ri, any_req, ack_det;

    // Enables are used raw so a change in IDLE acts in the same cycle.
    assign rw      = ~w5300_n_s & ena_w5300_int;
    assign rs      = sl811_s & ena_sl811_int;
    assign ri      = internal_s;
    assign any_req = (rw | rs | ri) & ena_zxbus_int;
    assign ack_det = ~m1_n_s & ~iorq_n_s;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          int_n_q, int_n_d;
    logic [1:0]    src_q, src_d;
    logic          ack_q, ack_d;
    logic          to_q, to_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        int_n_d = int_n_q;
        src_d   = src_q;
        ack_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ASSERT;
                    int_n_d = 1'b0;
                    src_d   = prio_src(rw, rs, ri);
                    cnt_d   = CW'(INT_LEN - 1);
                end
            end
            ST_ASSERT: begin
                // Acknowledge beats timeout, which beats a global disable.
                if (ack_det || cnt_q == '0 || !ena_zxbus_int) begin
                    state_d = ST_HOLDOFF;
                    int_n_d = 1'b1;
                    cnt_d   = CW'(HOLDOFF_LEN - 1);
                    ack_d   = ack_det;
                    to_d    = ~ack_det & (cnt_q == '0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                int_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            int_n_q <= 1'b1;
            src_q   <= SRC_NONE;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_n_q <= int_n_d;
            src_q   <= src_d;
            ack_q   <= ack_d;
            to_q    <= to_d;
        end
    end

    assign int_n       = int_n_q;
    assign int_src     = src_q;
    assign int_ack     = ack_q;
    assign int_timeout = to_q;

`ifdef ZX_INT_STATS_EN
    logic [7:0] count_q, count_d;

    // Counts on the edge that closes the int_ack cycle; a clear in that cycle wins.
    always_comb begin
        count_d = count_q;
        if (stats_clr) begin
            count_d = '0;
        end else if (ack_q && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign int_count = count_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign int_count        = '0;
`endif

endmodule

// File: tb/tb_zx_int_ctrl.sv
// tb/tb_zx_int_ctrl.sv - directed and randomized self-checking bench for zx_int_ctrl
module tb_zx_int_ctrl;

    localparam int INT_LEN     = 32;
    localparam int HOLDOFF_LEN = 8;
    localparam int LAT         = 3;
    localparam int GAP         = HOLDOFF_LEN + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       w5300_int_n, sl811_intrq, internal_int;
    logic       ena_w5300_int, ena_sl811_int, ena_zxbus_int;
    logic       zx_m1_n, zx_iorq_n;
    logic       int_n;
    logic [1:0] int_src;
    logic       int_ack, int_timeout;
    logic [7:0] int_count;
    logic       stats_clr;

    int tests = 0;
    int fails = 0;
    int ack_seen = 0;
    int to_seen = 0;

    always #5 clk = ~clk;

    zx_int_ctrl #(.INT_LEN(INT_LEN), .HOLDOFF_LEN(HOLDOFF_LEN)) dut (
        .clk(clk), .rst(rst),
        .w5300_int_n(w5300_int_n), .sl811_intrq(sl811_intrq), .internal_int(internal_int),
        .ena_w5300_int(ena_w5300_int), .ena_sl811_int(ena_sl811_int), .ena_zxbus_int(ena_zxbus_int),
        .zx_m1_n(zx_m1_n), .zx_iorq_n(zx_iorq_n),
        .int_n(int_n), .int_src(int_src), .int_ack(int_ack), .int_timeout(int_timeout),
        .int_count(int_count), .stats_clr(stats_clr)
    );

    always @(negedge clk) begin
        if (int_ack === 1'b1) ack_seen++;
        if (int_timeout === 1'b1) to_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input logic v, input int maxc, output int n);
        n = 0;
        while (int_n !== v && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic do_ack(input string tag);
        int n;
        zx_m1_n   = 1'b0;
        zx_iorq_n = 1'b0;
        wait_level(1'b1, 40, n);
        chk({tag, "_ack_lat"}, n, LAT);
        chk({tag, "_ack_pulse"}, int_ack, 1);
        zx_m1_n   = 1'b1;
        zx_iorq_n = 1'b1;
        tick();
        chk({tag, "_ack_clear"}, int_ack, 0);
    endtask

    // Reference rule: enabled W5300 first, then enabled SL811, then internal.
    function automatic logic [1:0] model_src(input logic w, input logic s, input logic i,
                                             input logic ew, input logic es);
        if (w && ew) return 2'b01;
        if (s && es) return 2'b10;
        if (i) return 2'b11;
        return 2'b00;
    endfunction

    initial begin
        int n, a0, t0, d;
        logic [1:0] last_src, exp_src;
        logic rw_, rs_, ri_, ew_, es_, ez_;

        rst = 1'b1;
        w5300_int_n = 1'b1; sl811_intrq = 1'b0; internal_int = 1'b0;
        ena_w5300_int = 1'b1; ena_sl811_int = 1'b1; ena_zxbus_int = 1'b1;
        zx_m1_n = 1'b1; zx_iorq_n = 1'b1; stats_clr = 1'b0;
        last_src = 2'b00;
        repeat (3) tick();
        chk("rst_int_n", int_n, 1);
        chk("rst_int_src", int_src, 0);
        chk("rst_int_ack", int_ack, 0);
        chk("rst_int_timeout", int_timeout, 0);
        chk("rst_int_count", int_count, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_int_n", int_n, 1);

        // Acknowledged SL811 pulse, then the level re-triggers after the hold-off gap.
        sl811_intrq = 1'b1;
        wait_level(1'b0, 20, n);
        chk("s1_lat", n, LAT);
        chk("s1_src", int_src, 2);
        last_src = 2'b10;
        d = $urandom_range(1, 20);
        repeat (d) tick();
        do_ack("s1");
        wait_level(1'b0, 20, n);
        chk("s1_gap", n + 1, GAP);
        sl811_intrq = 1'b0;
        chk("s1b_src", int_src, 2);
        do_ack("s1b");
        repeat (12) tick();
        chk("s1_no_retrigger", int_n, 1);

        // W5300 beats internal on every pulse while both are held.
        w5300_int_n = 1'b0;
        internal_int = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_level(1'b0, 20, n);
            if (k == 0) chk("s2_lat", n, LAT);
            else chk("s2_gap", n + 1, GAP);
            chk("s2_src", int_src, 1);
            repeat ($urandom_range(0, 10)) tick();
            if (k == 2) begin
                w5300_int_n = 1'b1;
                internal_int = 1'b0;
            end
            do_ack("s2");
        end
        last_src = 2'b01;
        repeat (12) tick();
        chk("s2_idle", int_n, 1);

        // Unacknowledged pulse times out, then re-triggers after the gap.
        t0 = to_seen;
        a0 = ack_seen;
        internal_int = 1'b1;
        wait_level(1'b0, 20, n);
        chk("s3_lat", n, LAT);
        wait_level(1'b1, 60, n);
        chk("s3_low_len", n, INT_LEN);
        chk("s3_timeout_pulse", int_timeout, 1);
        chk("s3_no_ack", int_ack, 0);
        tick();
        chk("s3_timeout_clear", int_timeout, 0);
        wait_level(1'b0, 30, n);
        chk("s3_gap", n + 1, GAP);
        internal_int = 1'b0;
        do_ack("s3");
        last_src = 2'b11;
        repeat (12) tick();
        chk("s3_timeouts", to_seen - t0, 1);
        chk("s3_acks", ack_seen - a0, 1);

        // Masking: disabled source is ignored; enable acts next edge; global disable ends the pulse quietly.
        ena_sl811_int = 1'b0;
        sl811_intrq = 1'b1;
        repeat (8) tick();
        chk("s4_masked", int_n, 1);
        ena_sl811_int = 1'b1;
        wait_level(1'b0, 5, n);
        chk("s4_enable_lat", n, 1);
        last_src = 2'b10;
        a0 = ack_seen;
        t0 = to_seen;
        repeat (5) tick();
        ena_zxbus_int = 1'b0;
        tick();
        chk("s4_disable_int_n", int_n, 1);
        chk("s4_disable_ack", int_ack, 0);
        chk("s4_disable_timeout", int_timeout, 0);
        sl811_intrq = 1'b0;
        repeat (12) tick();
        ena_zxbus_int = 1'b1;
        tick();
        chk("s4_reenable_idle", int_n, 1);
        chk("s4_no_ack_seen", ack_seen - a0, 0);
        chk("s4_no_to_seen", to_seen - t0, 0);

        // Reset in the middle of a pulse.
        internal_int = 1'b1;
        wait_level(1'b0, 20, n);
        chk("s5_lat", n, LAT);
        repeat (5) tick();
        a0 = ack_seen;
        t0 = to_seen;
        #2 rst = 1'b1;
        #1;
        chk("s5_async_int_n", int_n, 1);
        chk("s5_async_src", int_src, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_level(1'b0, 10, n);
        chk("s5_relaunch_lat", n, LAT);
        chk("s5_src", int_src, 3);
        chk("s5_no_pulses", (ack_seen - a0) + (to_seen - t0), 0);
        internal_int = 1'b0;
        do_ack("s5");
        last_src = 2'b11;
        repeat (12) tick();

        // Randomized source/enable mixes against the priority rule.
        for (int it = 0; it < 12; it++) begin
            rw_ = 1'($urandom); rs_ = 1'($urandom); ri_ = 1'($urandom);
            ew_ = 1'($urandom); es_ = 1'($urandom); ez_ = 1'($urandom);
            exp_src = model_src(rw_, rs_, ri_, ew_, es_);
            ena_w5300_int = ew_; ena_sl811_int = es_; ena_zxbus_int = ez_;
            w5300_int_n = ~rw_; sl811_intrq = rs_; internal_int = ri_;
            if (ez_ && exp_src != 2'b00) begin
                wait_level(1'b0, 10, n);
                chk("rnd_lat", n, LAT);
                chk("rnd_src", int_src, 32'(exp_src));
                last_src = exp_src;
                w5300_int_n = 1'b1; sl811_intrq = 1'b0; internal_int = 1'b0;
                do_ack("rnd");
            end else begin
                repeat (6) tick();
                chk("rnd_quiet_int_n", int_n, 1);
                chk("rnd_quiet_src", int_src, 32'(last_src));
                w5300_int_n = 1'b1; sl811_intrq = 1'b0; internal_int = 1'b0;
            end
            repeat (3) tick();
            ena_w5300_int = 1'b1; ena_sl811_int = 1'b1; ena_zxbus_int = 1'b1;
            repeat (12) tick();
        end

`ifdef ZX_INT_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("st_clear", int_count, 0);
        sl811_intrq = 1'b1;
        for (int p = 0; p < 300; p++) begin
            wait_level(1'b0, 20, n);
            if (p == 299) sl811_intrq = 1'b0;
            do_ack("st");
        end
        repeat (3) tick();
        chk("st_saturate", int_count, 255);
        sl811_intrq = 1'b1;
        wait_level(1'b0, 20, n);
        sl811_intrq = 1'b0;
        zx_m1_n = 1'b0;
        zx_iorq_n = 1'b0;
        wait_level(1'b1, 40, n);
        chk("st_ack_pulse", int_ack, 1);
        stats_clr = 1'b1;
        zx_m1_n = 1'b1;
        zx_iorq_n = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("st_clr_wins", int_count, 0);
        tick();
        chk("st_clr_hold", int_count, 0);
`else
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("st_disabled_count", int_count, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
